// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and the
// pointer-width helper used to size the circular-buffer pointers.
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Pointer width for a power-of-two depth; wraps DEPTH-1 -> 0 naturally.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port and one read port
// with a registered output. The array itself is never cleared; only the
// output register is reset so the FIFO presents dout = 0 after reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // Write port: no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Registered read port: loads only on an accepted read, otherwise holds.
    // A same-edge write to the same address returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_reg[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO: circular buffer with read/write pointers,
// registered occupancy count, flags decoded from that count, and
// overflow/underflow indications for rejected requests.
// Build option: define SYNC_FIFO_STICKY_ERR_EN to make overflow/underflow
// sticky until reset; otherwise they pulse for one cycle per rejection.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THR);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THR);

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic rd_acc;
    logic wr_acc;
    logic ram_we;

    // Status flags come only from the registered count.
    assign full         = (count_reg == FULL_CNT);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AFULL_CNT);
    assign almost_empty = (count_reg <= AEMPTY_CNT);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write when it is also being read.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    // Reset wins over a concurrent write; keep the array untouched then.
    assign ram_we = wr_acc && !reset;

    // Next-state for pointers, occupancy and error indications.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;

        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase

`ifdef SYNC_FIFO_STICKY_ERR_EN
        overflow_next  = overflow_reg  || (wr_en && !wr_acc);
        underflow_next = underflow_reg || (rd_en && !rd_acc);
`else
        overflow_next  = wr_en && !wr_acc;
        underflow_next = rd_en && !rd_acc;
`endif
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (din),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_reg),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=16, defaults).
// The driver keeps a queue model of the FIFO contents and pushes the
// expected read word for every accepted read; the monitor pops and compares
// one clock later, and checks flags/count against the model every cycle.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state (values expected after the upcoming clock edge).
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         m_count = 0;
    logic       m_ov = 1'b0;
    logic       m_un = 1'b0;
    logic       pend_valid = 1'b0;
    logic       pend_rd = 1'b0;
    logic       pend_clr = 1'b0;

    sync_fifo_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; updates the model before the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
        logic mrd;
        logic mwr;
        reset = rs;
        wr_en = w;
        rd_en = r;
        din   = d;
        if (rs) begin
            mq.delete();
            m_count  = 0;
            m_ov     = 1'b0;
            m_un     = 1'b0;
            pend_rd  = 1'b0;
            pend_clr = 1'b1;
        end else begin
            mrd = r && (m_count != 0);
            mwr = w && ((m_count != DEPTH) || mrd);
            if (mrd) exp_q.push_back(mq.pop_front());
            if (mwr) mq.push_back(d);
            m_count = m_count + int'(mwr) - int'(mrd);
            m_ov = STICKY ? (m_ov || (w && !mwr)) : (w && !mwr);
            m_un = STICKY ? (m_un || (r && !mrd)) : (r && !mrd);
            pend_rd  = mrd;
            pend_clr = 1'b0;
        end
        pend_valid = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] txn rst=%0b wr=%0b rd=%0b din=0x%02h -> dout=0x%02h count=%0d", rs, w, r, d, dout, count);
    endtask

    // Monitor: latch the expectation at the edge, compare at the falling edge.
    initial begin : monitor
        logic       v, take, clr, eo, eu;
        int         ec;
        logic [7:0] e;
        logic [7:0] last;
        last = 8'h00;
        forever begin
            @(posedge clk);
            v    = pend_valid;
            take = pend_rd;
            clr  = pend_clr;
            ec   = m_count;
            eo   = m_ov;
            eu   = m_un;
            @(negedge clk);
            if (v) begin
                if (clr) last = 8'h00;
                if (take) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("[TB] FAIL scoreboard_empty: got read with no expected word");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", 32'(dout), 32'(e));
                        last = e;
                    end
                end else begin
                    chk("dout_hold", 32'(dout), 32'(last));
                end
                chk("count",        32'(count),        32'(ec));
                chk("full",         32'(full),         32'(ec == DEPTH));
                chk("empty",        32'(empty),        32'(ec == 0));
                chk("almost_full",  32'(almost_full),  32'(ec >= DEPTH - 2));
                chk("almost_empty", 32'(almost_empty), 32'(ec <= 2));
                chk("overflow",     32'(overflow),     32'(eo));
                chk("underflow",    32'(underflow),    32'(eu));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_aempty", 32'(almost_empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_dout", 32'(dout), 32'h00);

        // Fill with 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            if (i == 13) chk("afull_at_13", 32'(almost_full), 32'd0);
            if (i == 14) chk("afull_at_14", 32'(almost_full), 32'd1);
        end
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 8'h99, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);

        // Drain: 0x01..0x10 in order, then one rejected read.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_last", 32'(dout), 32'h10);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("udf_flag", 32'(underflow), 32'd1);
        chk("udf_dout_hold", 32'(dout), 32'h10);

        // Pointer wrap: 4 x (write 10, read 10), rising data.
        for (int rep = 0; rep < 4; rep++) begin
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h20 + rep * 10 + i), 1'b0);
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        end
        chk("wrap_last", 32'(dout), 32'h47);

        // Full with simultaneous read/write of 0xAA.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("fullrw_dout", 32'(dout), 32'h60);
        chk("fullrw_count", 32'(count), 32'd16);
        chk("fullrw_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("fullrw_aa_last", 32'(dout), 32'hAA);

        // Empty with simultaneous read/write of 0x55.
        step(1'b1, 1'b1, 8'h55, 1'b0);
        chk("emptyrw_udf", 32'(underflow), 32'd1);
        chk("emptyrw_count", 32'(count), 32'd1);
        chk("emptyrw_dout_hold", 32'(dout), 32'hAA);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("emptyrw_read", 32'(dout), 32'h55);

        // Reset with 7 words stored and a concurrent write.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h7F, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd7);
        chk("pre_rst_ovf", 32'(overflow), 32'(STICKY));
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_rst_udf", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
